assoc_kv_store: RTL

ASSOC_KV_STORE -- requirements
Module: assoc_kv_store

---
 rtl/assoc_kv_pkg.sv | 17 +
 rtl/assoc_free_finder.sv | 25 ++
 rtl/assoc_kv_store.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/assoc_kv_pkg.sv
// Shared types for the associative key/value store: request opcodes and scan FSM states.
package assoc_kv_pkg;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        DELETE = 2'd2,
        CLEAR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/assoc_free_finder.sv
// Purpose: lowest-index invalid entry priority encoder with a none-free flag.
// Latency: purely combinational.
// Backpressure: none; output follows the valid vector.
module assoc_free_finder #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         valid,
    output logic [$clog2(DEPTH)-1:0] free_idx,
    output logic                     none_free
);
    localparam int IDX_W = $clog2(DEPTH);

    // Walk from the top down so the last assignment wins for the lowest free slot.
    always_comb begin
        free_idx  = '0;
        none_free = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx  = IDX_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/assoc_kv_store.sv
// Purpose: small associative key/value store with READ/WRITE/DELETE/CLEAR by linear scan.
// Latency: hit at index i -> i+2 cycles, miss -> DEPTH+1 cycles, CLEAR -> 1 cycle.
// Backpressure: one op in flight; req_ready only in IDLE, response held until rsp_ready.
module assoc_kv_store
    import assoc_kv_pkg::*;
#(
    parameter int KEY_W = 32,
    parameter int VAL_W = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [KEY_W-1:0]         req_key,
    input  logic [VAL_W-1:0]         req_val,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [VAL_W-1:0]         rsp_val,
    output logic                     rsp_hit,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   num
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [KEY_W-1:0] key_mem [DEPTH];
    logic [VAL_W-1:0] val_mem [DEPTH];
    logic [DEPTH-1:0] valid;

    state_e           state;
    op_e              op_q;
    logic [KEY_W-1:0] key_q;
    logic [VAL_W-1:0] val_q;
    logic [IDX_W-1:0] idx;

    logic             hit;
    logic             scan_done;
    logic [IDX_W-1:0] free_idx;
    logic             none_free;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;

    assoc_free_finder #(.DEPTH(DEPTH)) u_free (
        .valid     (valid),
        .free_idx  (free_idx),
        .none_free (none_free)
    );

    assign req_ready = (state == IDLE);
    assign hit       = valid[idx] && (key_mem[idx] == key_q);
    assign scan_done = (state == SCAN) && (hit || idx == IDX_W'(DEPTH - 1));

    // Payload RAM carries no reset; only valid bits decide whether an entry exists.
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = idx;
        if (scan_done && op_q == WRITE) begin
            if (hit) begin
                mem_we = 1'b1;
            end else if (!none_free) begin
                mem_we  = 1'b1;
                mem_idx = free_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            key_mem[mem_idx] <= key_q;
            val_mem[mem_idx] <= val_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            num       <= '0;
            idx       <= '0;
            op_q      <= READ;
            key_q     <= '0;
            val_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_val   <= '0;
            rsp_hit   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= op_e'(req_op);
                        key_q <= req_key;
                        val_q <= req_val;
                        idx   <= '0;
                        if (op_e'(req_op) == CLEAR) begin
                            valid     <= '0;
                            num       <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (scan_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= hit;
                        case (op_q)
                            READ: begin
                                rsp_val <= hit ? val_mem[idx] : '0;
                            end
                            WRITE: begin
                                if (!hit) begin
                                    if (none_free) begin
                                        rsp_err <= 1'b1;
                                    end else begin
                                        valid[free_idx] <= 1'b1;
                                        num             <= num + 1'b1;
                                    end
                                end
                            end
                            DELETE: begin
                                if (hit) begin
                                    valid[idx] <= 1'b0;
                                    num        <= num - 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_val   <= '0;
                        rsp_hit   <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
